// File: rtl/regfile_alu_seq.sv
// Sequenced register file + ALU: one start/done handshake runs read, execute and write-back.
// Optional shift operations (SLL/SRL/SRA) are enabled by defining REGFILE_ALU_SHIFT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; external register writes honoured
// ST_RD   | operand fetch from latched rs1/rs2 (or immediate)
// ST_EX   | ALU evaluation; result, zero and error flag registered
// ST_WB   | write-back to rd unless error or rd is x0; done issued
module regfile_alu_seq #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [3:0]      ctrl,
  input  logic            src_sel,
  input  logic [XLEN-1:0] imm,
  input  logic            ext_we,
  input  logic [AW-1:0]   ext_addr,
  input  logic [XLEN-1:0] ext_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_EX, ST_WB} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_busy;
  logic            w_accept;
  logic            w_ext_wr;
  logic            w_wb_wr;

  logic [XLEN-1:0] r_regs [NREGS];
  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [AW-1:0]   r_rd;
  logic [3:0]      r_ctrl;
  logic            r_src_sel;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_err;
  logic            r_done;
  logic            r_err_out;

  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_alu;
  logic            w_alu_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_ext_wr    = 1'b0;
    w_wb_wr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ext_wr = ext_we && (ext_addr != '0);
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_EX;
      end
      ST_EX: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        w_busy      = 1'b1;
        w_wb_wr     = !r_err && (r_rd != '0);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // x0 is never written, but the read mux keeps it zero regardless of array contents
  assign w_rs1_val = (r_rs1 == '0) ? '0 : r_regs[r_rs1];
  assign w_rs2_val = (r_rs2 == '0) ? '0 : r_regs[r_rs2];
  assign dbg_data  = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

`ifdef REGFILE_ALU_SHIFT_EN
  localparam int SHW = $clog2(XLEN);
  logic [SHW-1:0] w_shamt;
  assign w_shamt = r_op_b[SHW-1:0];
`endif

  always_comb begin
    w_alu     = '0;
    w_alu_err = 1'b0;
    case (r_ctrl)
      4'd0:  w_alu = r_op_a & r_op_b;
      4'd1:  w_alu = r_op_a | r_op_b;
      4'd2:  w_alu = r_op_a + r_op_b;
      4'd3:  w_alu = r_op_a ^ r_op_b;
      4'd6:  w_alu = r_op_a - r_op_b;
      4'd7:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_op_a) < $signed(r_op_b))};
      4'd12: w_alu = ~(r_op_a | r_op_b);
`ifdef REGFILE_ALU_SHIFT_EN
      4'd8:  w_alu = r_op_a << w_shamt;
      4'd9:  w_alu = r_op_a >> w_shamt;
      4'd10: w_alu = $unsigned($signed(r_op_a) >>> w_shamt);
`endif
      default: w_alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_src_sel <= 1'b0;
      r_imm     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_err_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rs1     <= rs1;
        r_rs2     <= rs2;
        r_rd      <= rd;
        r_ctrl    <= ctrl;
        r_src_sel <= src_sel;
        r_imm     <= imm;
      end
      if (r_state == ST_RD) begin
        r_op_a <= w_rs1_val;
        r_op_b <= r_src_sel ? r_imm : w_rs2_val;
      end
      if (r_state == ST_EX) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
        r_err    <= w_alu_err;
      end
      // done/err are a single-cycle pulse in the cycle after write-back
      r_done    <= (r_state == ST_WB);
      r_err_out <= (r_state == ST_WB) && r_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_ext_wr) begin
      r_regs[ext_addr] <= ext_data;
    end else if (w_wb_wr) begin
      r_regs[r_rd] <= r_result;
    end
  end

  assign busy   = w_busy;
  assign done   = r_done;
  assign err    = r_err_out;
  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Scoreboard bench for regfile_alu_seq: expected results queued at issue, checked on done.
module tb_regfile_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  ctrl;
  logic        src_sel;
  logic [31:0] imm;
  logic        ext_we;
  logic [4:0]  ext_addr;
  logic [31:0] ext_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        busy, done, err, zero;
  logic [31:0] result;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_regs [32];
  int          total = 0;
  int          bad   = 0;

  regfile_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
    .ctrl(ctrl), .src_sel(src_sel), .imm(imm), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_data(ext_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy),
    .done(done), .err(err), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = 32'h0;
    e.e   = 1'b0;
    case (c)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd3:  e.res = a ^ b;
      4'd6:  e.res = a - b;
      4'd7:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: e.res = ~(a | b);
`ifdef REGFILE_ALU_SHIFT_EN
      4'd8:  e.res = a << b[4:0];
      4'd9:  e.res = a >> b[4:0];
      4'd10: e.res = $unsigned($signed(a) >>> b[4:0]);
`endif
      default: e.e = 1'b1;
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_zero", {31'd0, zero}, {31'd0, e.z});
        chk("sb_err", {31'd0, err}, {31'd0, e.e});
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    q.delete();
  endtask

  task automatic ext_write(input logic [4:0] a, input logic [31:0] d);
    ext_we = 1'b1; ext_addr = a; ext_data = d;
    @(negedge clk);
    ext_we = 1'b0;
    if (a != 5'd0) m_regs[a] = d;
  endtask

  // Caller is at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                        input logic [3:0] c, input logic sel, input logic [31:0] im,
                        input logic xw, input logic [4:0] xa, input logic [31:0] xd,
                        input bit poke);
    logic [31:0] opa, opb;
    exp_t e;
    int lat;
    if (xw && xa != 5'd0) m_regs[xa] = xd;
    opa = m_regs[a1];
    opb = sel ? im : m_regs[a2];
    e = model_alu(c, opa, opb);
    q.push_back(e);
    if (!e.e && ad != 5'd0) m_regs[ad] = e.res;
    rs1 = a1; rs2 = a2; rd = ad; ctrl = c; src_sel = sel; imm = im;
    ext_we = xw; ext_addr = xa; ext_data = xd;
    dbg_addr = ad;
    start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; ext_we = 1'b0;
        chk("busy_run", {31'd0, busy}, 32'd1);
        if (poke) begin
          start = 1'b1; rs1 = 5'd4; rs2 = 5'd4; rd = 5'd9; ctrl = 4'd2; src_sel = 1'b0;
          ext_we = 1'b1; ext_addr = 5'd9; ext_data = 32'hA5A5;
        end
      end
      if (n == 3) begin
        start = 1'b0; ext_we = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, 32'd4);
    chk("dbg_rd", dbg_data, m_regs[ad]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    start = 0; rs1 = 0; rs2 = 0; rd = 0; ctrl = 0; src_sel = 0; imm = 0;
    ext_we = 0; ext_addr = 0; ext_data = 0; dbg_addr = 0;
    @(negedge clk);
    do_reset();

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0];
      #1 chk("rst_dbg", dbg_data, 32'd0);
    end

    ext_write(5'd4, 32'h10E3);
    ext_write(5'd0, 32'hDEAD);
    dbg_addr = 5'd0;
    #1 chk("x0_ext_discard", dbg_data, 32'd0);
    dbg_addr = 5'd4;
    #1 chk("x4_ext", dbg_data, 32'h10E3);

    run_op(5'd3, 5'd4, 5'd5,  4'd2,  1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd3, 5'd4, 5'd6,  4'd6,  1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd4, 5'd19, 4'd6,  1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd0, 5'd0,  4'd2,  1'b1, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd3, 5'd0, 5'd11, 4'd7,  1'b1, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd6, 5'd4, 5'd12, 4'd7,  1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd6, 5'd20, 4'd0,  1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd6, 5'd21, 4'd1,  1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd6, 5'd22, 4'd3,  1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd0, 5'd23, 4'd12, 1'b1, 32'h0000F000, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd0, 5'd13, 4'd9,  1'b1, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd6, 5'd0, 5'd24, 4'd10, 1'b1, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd0, 5'd25, 4'd8,  1'b1, 32'h8, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd4, 5'd4, 5'd5,  4'd15, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

    // ext write and start in the same IDLE cycle, then back-to-back dependent ops
    run_op(5'd14, 5'd0, 5'd15, 4'd2, 1'b1, 32'h1, 1'b1, 5'd14, 32'h1234, 1'b0);
    run_op(5'd15, 5'd0, 5'd16, 4'd2, 1'b1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0);
    run_op(5'd16, 5'd0, 5'd17, 4'd2, 1'b1, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0);
    dbg_addr = 5'd17;
    #1 chk("b2b_x17", dbg_data, 32'h1237);

    run_op(5'd4, 5'd4, 5'd26, 4'd2, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    dbg_addr = 5'd9;
    #1 chk("busy_ext_ignored", dbg_data, 32'd0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("busy_start_ignored", cnt, 32'd0);

    // reset during EX aborts the operation
    rs1 = 5'd4; rs2 = 5'd4; rd = 5'd7; ctrl = 4'd2; src_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'd0);
    dbg_addr = 5'd7;
    #1 chk("abort_x7", dbg_data, 32'd0);
    dbg_addr = 5'd4;
    #1 chk("abort_x4", dbg_data, 32'd0);

    repeat (4) @(negedge clk);
    chk("sb_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_alu_seq.md
# regfile_alu_seq

Parametrised, sequenced register-file-plus-ALU datapath: one start/done handshake executes a full read → execute → write-back operation internally, replacing the testbench-driven read/compute/write stepping of the earlier register file + ALU pairing. Width, register count and immediate operand selection are generic. An external load port and a debug read port give the bench and future control logic direct register access.

## Interface
- XLEN, 32, datapath width in bits (≥ 8)
- NREGS, 32, number of registers (power of two, ≥ 2); register 0 reads as zero
- AW, $clog2(NREGS), register address width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request an operation; sampled only in IDLE
- rs1, rs2, rd  in  AW each  source/destination register addresses
- ctrl  in  4  ALU operation code
- src_sel  in  1  0: operand B = reg[rs2]; 1: operand B = imm
- imm  in  XLEN  immediate operand
- ext_we  in  1  external register write enable (honoured only in IDLE)
- ext_addr  in  AW  external write address
- ext_data  in  XLEN  external write data
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  combinational reg[dbg_addr] (0 when dbg_addr = 0)
- busy  out  1  high in RD, EX, WB
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; unsupported ctrl
- result  out  XLEN  registered ALU result of the last operation
- zero  out  1  registered, result == 0 over full XLEN

## Operation
- FSM states IDLE → RD → EX → WB → IDLE; no other transitions except reset.
- IDLE: start = 1 latches rs1, rs2, rd, ctrl, src_sel, imm; next state RD. start outside IDLE ignored.
- RD: register opA = reg[rs1], opB = src_sel ? imm : reg[rs2]; x0 reads 0.
- EX: compute, register result, zero, err flag.
- WB: if !err and rd ≠ 0, reg[rd] ← result; next state IDLE.
- ctrl codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed, result 1/0), 12 NOR, 3 XOR.
- ADD/SUB wrap modulo 2^XLEN; no carry/overflow outputs.
- Unsupported code: result = 0, zero = 1, err = 1, no write-back.
- ext_we in IDLE writes reg[ext_addr] ← ext_data at the edge; ext_addr = 0 discarded; ext_we while busy ignored.
- ext_we and start in the same IDLE cycle: both take effect; RD sees the new value.

## Timing
- Reset (rst_n low at an edge): state IDLE, busy 0, done 0, err 0, result 0, zero 0, all registers 0.
- Reset mid-operation aborts; no write-back occurs.
- start sampled at edge E0; busy high after E0 through E3; write-back and done at E3.
- done (and err) high exactly one cycle after E3; result/zero hold until next EX.
- FSM is in IDLE during the done cycle; a new start there is accepted (back-to-back issue every 4 cycles).
- Written value visible on dbg_data in the done cycle and readable by the next operation's RD.

## Configuration
- REGFILE_ALU_SHIFT_EN defined: ctrl 8 SLL, 9 SRL, 10 SRA; shift amount = opB[$clog2(XLEN)-1:0]; SRA sign-fills.
- Not defined: codes 8, 9, 10 are unsupported (err = 1, result 0, no write-back).

## Test plan
- Reset: rst_n low 2 cycles → busy/done/err 0, result 0, dbg_data 0 for every address.
- ext write x4 = 4323 (0x10E3), start ADD rs1=3, rs2=4, rd=5 → done after 4 edges, result 0x10E3, x5 = 0x10E3, zero 0.
- SUB rs1=3, rs2=4, rd=6 (x3 = 0) → result 0xFFFFEF1D, x6 written; SUB rs1=4, rs2=4 → result 0, zero 1.
- src_sel=1, imm=0xFFFFFFFF, ADD rs1=4, rd=0 → result 0x10E2, x0 still reads 0; SLT x3 < imm(-1) → 0.
- ctrl=9 without REGFILE_ALU_SHIFT_EN → err 1, rd unchanged; with macro, x4 SRL imm=4 → 0x10E.
- Assert rst_n low in EX of ADD to rd=7 → no done, x7 = 0; start during busy and ext_we during busy ignored.
